// File: rtl/sum_capture_fifo_if.sv
// Handshake and statistics bundle between the adder result producer/consumer and sum_capture_fifo.
// slave: the FIFO's view (takes in_*, out_ready and clr; drives the rest).
// master: the environment's view (the mirror image).
interface sum_capture_fifo_if #(
  parameter int Width = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);

  // Producer side: one adder result per accepted beat
  logic                     in_valid;
  logic                     in_ready;
  logic [Width-1:0]         in_sum;
  logic                     in_cout;

  // Consumer side: show-ahead head entry
  logic                     out_valid;
  logic                     out_ready;
  logic [Width-1:0]         out_sum;
  logic                     out_cout;

  // Occupancy and debug statistics
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_W-1:0]         carry_cnt;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     overflow;
  logic                     clr;

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready, clr,
    output in_ready, out_valid, out_sum, out_cout, level, carry_cnt, drop_cnt, overflow
  );

  modport master (
    output in_valid, in_sum, in_cout, out_ready, clr,
    input  in_ready, out_valid, out_sum, out_cout, level, carry_cnt, drop_cnt, overflow
  );

endinterface

// File: rtl/sum_capture_fifo.sv
// Buffers {cout, sum} adder results in a DEPTH-entry FIFO and tracks carry/drop statistics.
// Latency: push to out_valid is 1 cycle; the head entry is presented combinationally (show-ahead).
// Backpressure: in_ready = ~full (no pass-through when full); pushes while full are dropped and counted.
module sum_capture_fifo #(
  parameter int Width = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_capture_fifo_if.slave  io_fifo
);

  // Index bits address the storage; one extra MSB distinguishes full from empty.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0]    PtrOne = PW'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Storage: each entry is {cout, sum}; contents are deliberately not reset.
  logic [Width:0]    r_mem [DEPTH];

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_carry_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_overflow;

  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_carry_evt;
  logic [Width:0]    w_head;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // Equal pointers mean empty; equal index with opposite wrap bit means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Full blocks the push even when a pop happens in the same cycle; empty ignores out_ready.
  assign w_push      = io_fifo.in_valid & ~w_full;
  assign w_pop       = io_fifo.out_ready & ~w_empty;
  assign w_drop      = io_fifo.in_valid & w_full;
  assign w_carry_evt = w_push & io_fifo.in_cout;

  assign w_head = r_mem[w_rd_idx];

  assign io_fifo.in_ready  = ~w_full;
  assign io_fifo.out_valid = ~w_empty;
  // Stale storage is masked so an empty FIFO always shows zero.
  assign io_fifo.out_sum   = w_empty ? '0   : w_head[Width-1:0];
  assign io_fifo.out_cout  = w_empty ? 1'b0 : w_head[Width];
  // Modulo difference of the wrap-extended pointers gives 0..DEPTH directly.
  assign io_fifo.level     = r_wr_ptr - r_rd_ptr;
  assign io_fifo.carry_cnt = r_carry_cnt;
  assign io_fifo.drop_cnt  = r_drop_cnt;
  assign io_fifo.overflow  = r_overflow;

  // Write the accepted result into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= {io_fifo.in_cout, io_fifo.in_sum};
    end
  end

  // Advance write/read pointers on accepted push/pop; reset discards all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
    end
  end

  // Count accepted carry-out results, saturating; clr takes priority over a count event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= '0;
    end else if (io_fifo.clr) begin
      r_carry_cnt <= '0;
    end else if (w_carry_evt && (r_carry_cnt != CntMax)) begin
      r_carry_cnt <= r_carry_cnt + CntOne;
    end
  end

  // Count rejected pushes, saturating; clr takes priority over a drop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (io_fifo.clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != CntMax)) begin
      r_drop_cnt <= r_drop_cnt + CntOne;
    end
  end

  // Sticky overflow flag: set by any drop, cleared only by clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (io_fifo.clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_capture_fifo.sv
// Self-checking bench for sum_capture_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model with saturating integer statistics.
module tb_sum_capture_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sum_capture_fifo_if #(.Width(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_if ();

  sum_capture_fifo #(.Width(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_fifo (u_if)
  );

  // Reference model state
  logic [WIDTH:0] m_q[$];
  int             m_carry;
  int             m_drop;
  bit             m_ovf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_carry = 0;
    m_drop  = 0;
    m_ovf   = 1'b0;
  endtask

  // Compare every DUT output against the model.
  task automatic check_outputs();
    logic [WIDTH:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    check_val("in_ready",  32'(u_if.in_ready),  32'(m_q.size() < DEPTH));
    check_val("out_valid", 32'(u_if.out_valid), 32'(m_q.size() != 0));
    check_val("out_sum",   32'(u_if.out_sum),   32'(head[WIDTH-1:0]));
    check_val("out_cout",  32'(u_if.out_cout),  32'(head[WIDTH]));
    check_val("level",     32'(u_if.level),     32'(m_q.size()));
    check_val("carry_cnt", 32'(u_if.carry_cnt), 32'(m_carry));
    check_val("drop_cnt",  32'(u_if.drop_cnt),  32'(m_drop));
    check_val("overflow",  32'(u_if.overflow),  32'(m_ovf));
  endtask

  // One clock cycle: drive inputs, check outputs before the edge, then advance the model.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] s, input logic c,
                       input logic r, input logic cl);
    bit push, pop, drp;
    u_if.in_valid  = v;
    u_if.in_sum    = s;
    u_if.in_cout   = c;
    u_if.out_ready = r;
    u_if.clr       = cl;
    #1;
    check_outputs();
    push = v && (m_q.size() < DEPTH);
    pop  = r && (m_q.size() != 0);
    drp  = v && (m_q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back({c, s});
    if (cl) begin
      m_carry = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
    end else begin
      if (push && c && m_carry < CMAX) m_carry++;
      if (drp && m_drop < CMAX) m_drop++;
      if (drp) m_ovf = 1'b1;
    end
  endtask

  task automatic push_rand(input logic r);
    cycle(1'b1, 8'($urandom), 1'($urandom), r, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_q.size() != 0 && guard < 4 * DEPTH) begin
      cycle(1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0);
      guard++;
    end
    check_val("drain_empty", 32'(u_if.out_valid), 32'd0);
  endtask

  initial begin
    int d0;
    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_sum    = '0;
    u_if.in_cout   = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.clr       = 1'b0;
    model_clear();

    // Reset state, held over a few edges
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Idle after reset
    repeat (2) cycle(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    check_val("idle_in_ready", 32'(u_if.in_ready), 32'd1);
    check_val("idle_level",    32'(u_if.level),    32'd0);

    // Two adder results, consumer stalled
    cycle(1'b1, 8'h1B, 1'b0, 1'b0, 1'b0);
    check_val("first_head_sum",  32'(u_if.out_sum),   32'h1B);
    check_val("first_head_cout", 32'(u_if.out_cout),  32'd0);
    check_val("first_valid",     32'(u_if.out_valid), 32'd1);
    cycle(1'b1, 8'h09, 1'b1, 1'b0, 1'b0);
    check_val("two_level", 32'(u_if.level),     32'd2);
    check_val("two_carry", 32'(u_if.carry_cnt), 32'd1);
    check_val("two_head",  32'(u_if.out_sum),   32'h1B);
    drain();

    // Five pushes into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      push_rand(1'b0);
      if (i == 3) check_val("full_in_ready", 32'(u_if.in_ready), 32'd0);
    end
    check_val("five_drop",     32'(u_if.drop_cnt), 32'd1);
    check_val("five_overflow", 32'(u_if.overflow), 32'd1);
    check_val("five_level",    32'(u_if.level),    32'd4);
    drain();

    // Steady push+pop at level 2 with incrementing sums across pointer wrap
    cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 8'(k + 2), 1'b0, 1'b1, 1'b0);
      check_val("stream_level", 32'(u_if.level),   32'd2);
      check_val("stream_head",  32'(u_if.out_sum), 32'(k + 1));
    end
    drain();

    // Full with simultaneous pop request: pop happens, push is rejected
    repeat (4) push_rand(1'b0);
    d0 = m_drop;
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check_val("fullpop_level", 32'(u_if.level),    32'd3);
    check_val("fullpop_drop",  32'(u_if.drop_cnt), 32'(d0 + 1));

    // Asynchronous reset mid-stream at level 3
    u_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_val("arst_valid",    32'(u_if.out_valid), 32'd0);
    check_val("arst_level",    32'(u_if.level),     32'd0);
    check_val("arst_in_ready", 32'(u_if.in_ready),  32'd1);
    check_val("arst_out_sum",  32'(u_if.out_sum),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // clr coinciding with a drop wins
    repeat (4) push_rand(1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    check_val("pre_clr_ovf", 32'(u_if.overflow), 32'd1);
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
    check_val("clr_drop", 32'(u_if.drop_cnt), 32'd0);
    check_val("clr_ovf",  32'(u_if.overflow), 32'd0);
    check_val("clr_keep", 32'(u_if.level),    32'd4);

    // Drop counter saturation
    repeat (CMAX + 20) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    check_val("drop_sat", 32'(u_if.drop_cnt), 32'(CMAX));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

    // Random traffic, heavy on carries so carry_cnt saturates
    repeat (1500) begin
      cycle(1'($urandom_range(0, 99) < 75), 8'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < 65), 1'b0);
    end
    check_val("carry_sat", 32'(u_if.carry_cnt), 32'(m_carry));

    // Random traffic with occasional clr
    repeat (800) begin
      cycle(1'($urandom_range(0, 99) < 60), 8'($urandom),
            1'($urandom), 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3));
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
